instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/control_signals_pkg.sv | 33 +++
 rtl/instr_sequencer_retire_counter.sv | 21 ++
 rtl/instr_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/control_signals_pkg.sv
// Shared control-unit types: datapath select enums plus the sequencer state encoding.
package control_signals;

    typedef enum logic [1:0] {
        ALU_SRC_REG,
        ALU_SRC_IMM
    } Alu_Src_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } Alu_Operation_t;

    typedef enum logic [1:0] {
        REG_DATA_ALU,
        REG_DATA_MEM,
        REG_DATA_PC4
    } Reg_Data_Src_t;

    // Encoding is visible on state_out, so keep these values fixed.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4
    } Seq_State_t;

endpackage

// File: rtl/instr_sequencer_retire_counter.sv
// 32-bit retired-instruction counter with synchronous clear; wraps naturally.
module retire_counter (
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] count
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= 32'd0;
        end else if (enable) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: drives fetch/memory handshakes and datapath strobes.
module instr_sequencer
    import control_signals::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        branch_ctrl,
    input  logic        alu_zero_in,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src_branch,
    output logic        reg_write_en,
    output logic        illegal_instr,
    output logic [2:0]  state_out,
    output logic [31:0] retired_cnt
);

    Seq_State_t state;
    Seq_State_t next_state;
    logic       retire;
    logic       is_branch;
    logic       is_mem;
    logic       is_alu;

    // Instruction class as seen in EXECUTE; anything not matching is illegal.
    assign is_branch = branch_ctrl && !mem_read && !mem_write;
    assign is_mem    = !branch_ctrl && (mem_read ^ mem_write);
    assign is_alu    = !branch_ctrl && !mem_read && !mem_write && reg_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:     if (imem_ready) next_state = DECODE;
            DECODE:    next_state = EXECUTE;
            EXECUTE: begin
                if (is_mem)      next_state = MEM;
                else if (is_alu) next_state = WRITEBACK;
                else             next_state = FETCH;
            end
            MEM:       if (dmem_ready) next_state = mem_read ? WRITEBACK : FETCH;
            WRITEBACK: next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src_branch = 1'b0;
        reg_write_en  = 1'b0;
        illegal_instr = 1'b0;
        retire        = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            EXECUTE: begin
                if (is_branch) begin
                    pc_write      = 1'b1;
                    pc_src_branch = alu_zero_in;
                    retire        = 1'b1;
                end else if (!is_mem && !is_alu) begin
                    pc_write      = 1'b1;
                    illegal_instr = 1'b1;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready && !mem_read) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
            end
            WRITEBACK: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                retire       = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any in-flight handshake; only the fetch request may show.
        if (rst) begin
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src_branch = 1'b0;
            reg_write_en  = 1'b0;
            illegal_instr = 1'b0;
            retire        = 1'b0;
        end
    end

    assign state_out = state;

    retire_counter u_retire_counter (
        .clk    (clk),
        .clear  (rst),
        .enable (retire),
        .count  (retired_cnt)
    );

endmodule
